// File: rtl/pi_write_port.sv
// Pi register write port: filters Pi write strobes, stages address/data words,
// launches 68k bus requests and holds the bus-control drive bits.
//
// state    | meaning
// REQ_IDLE | no bus request outstanding; a launch is accepted
// REQ_BUSY | request in progress; only a launch coincident with bus_done is accepted
module pi_write_port #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pi_wr_n,
  input  logic        pi_rd_n,
  input  logic [2:0]  pi_a,
  input  logic [15:0] pi_data_in,
  input  logic        bus_done,
  output logic        req_start,
  output logic        req_active,
  output logic [31:0] req_data_write,
  output logic [23:0] req_address,
  output logic [2:0]  req_fc,
  output logic        req_rw,
  output logic [1:0]  req_size,
  output logic        r_reset_drive,
  output logic        r_halt_drive,
  output logic        r_br_drive,
  output logic        overrun
);

  localparam int CNT_W = $clog2(MIN_LOW + 1);
  localparam int IN_W  = 21;

  typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_t;

  req_state_t        state, state_nxt;
  logic [IN_W-1:0]   sync_q [SYNC_STAGES];
  logic              wr_s, rd_s;
  logic [2:0]        a_s;
  logic [15:0]       d_s;
  logic [CNT_W-1:0]  low_cnt;
  logic              armed;
  logic              qualified;
  logic              wr_event;
  logic              is_launch;
  logic              is_ctrl;
  logic              launch_ok;
  logic              launch_drop;
  logic [31:0]       stage_data;
  logic [15:0]       stage_addr;

  // Strobes, address and data share one synchronizer chain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pi_wr_n, pi_rd_n, pi_a, pi_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_s = sync_q[SYNC_STAGES-1][20];
  assign rd_s = sync_q[SYNC_STAGES-1][19];
  assign a_s  = sync_q[SYNC_STAGES-1][18:16];
  assign d_s  = sync_q[SYNC_STAGES-1][15:0];

  assign qualified = !wr_s && rd_s;

  // armed stays low until the strobe has been seen high after reset, so a
  // strobe already held low across reset release is never taken as a write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      low_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      if (wr_s) armed <= 1'b1;
      if (qualified && armed) begin
        if (low_cnt != CNT_W'(MIN_LOW)) low_cnt <= low_cnt + CNT_W'(1);
      end else begin
        low_cnt <= '0;
      end
    end
  end

  assign wr_event  = qualified && armed && (low_cnt == CNT_W'(MIN_LOW - 1));
  assign is_launch = wr_event && (a_s == 3'd3);
  assign is_ctrl   = wr_event && (a_s == 3'd4);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= REQ_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    launch_ok   = 1'b0;
    launch_drop = 1'b0;
    case (state)
      REQ_IDLE: begin
        if (is_launch) begin
          launch_ok = 1'b1;
          state_nxt = REQ_BUSY;
        end
      end
      REQ_BUSY: begin
        if (is_launch && bus_done) begin
          launch_ok = 1'b1;
        end else if (is_launch) begin
          launch_drop = 1'b1;
        end else if (bus_done) begin
          state_nxt = REQ_IDLE;
        end
      end
      default: state_nxt = REQ_IDLE;
    endcase
  end

  assign req_active = (state == REQ_BUSY);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stage_data <= '0;
      stage_addr <= '0;
    end else if (wr_event) begin
      case (a_s)
        3'd0:    stage_data[15:0]  <= d_s;
        3'd1:    stage_data[31:16] <= d_s;
        3'd2:    stage_addr        <= d_s;
        default: ;
      endcase
    end
  end

  // Committed fields only move on an accepted launch; a dropped one leaves them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_start      <= 1'b0;
      req_data_write <= '0;
      req_address    <= '0;
      req_fc         <= '0;
      req_rw         <= 1'b0;
      req_size       <= '0;
    end else begin
      req_start <= launch_ok;
      if (launch_ok) begin
        req_data_write <= stage_data;
        req_address    <= {d_s[7:0], stage_addr};
        req_fc         <= d_s[13:11];
        req_rw         <= d_s[10];
        req_size       <= d_s[9:8];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_reset_drive <= 1'b0;
      r_halt_drive  <= 1'b0;
      r_br_drive    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (is_ctrl) begin
        if (d_s[0]) r_reset_drive <= d_s[15];
        if (d_s[1]) r_halt_drive  <= d_s[15];
        if (d_s[2]) r_br_drive    <= d_s[15];
      end
      if (launch_drop)           overrun <= 1'b1;
      else if (is_ctrl && d_s[3]) overrun <= 1'b0;
    end
  end

endmodule
